// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares the HPS virtual-disk sector channel between the SPI
// virtual SD card (requester 0) and the drive/cart image loader (requester 1).
//
// Handshake: a requester asks by holding exactly one of rd/wr high together
// with its lba. A grant raises sd_rd/sd_wr one cycle later. The HPS raises
// sd_ack for the whole buffer transfer; the strobe drops on the ack rise, and
// the ack fall ends the transfer with a one-cycle done pulse. A timeout or an
// image change ends it with a one-cycle err pulse instead. The requester must
// drop its level in the cycle after done/err; a level still high in IDLE is a
// new request. Grants alternate round-robin when both requesters are waiting.
module sd_req_arbiter #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd16000000,
  parameter logic [19:0] ACT_HOLD    = 20'd1000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] req0_lba,
  input  logic        req0_rd,
  input  logic        req0_wr,
  output logic        req0_done,
  output logic        req0_err,
  input  logic [31:0] req1_lba,
  input  logic        req1_rd,
  input  logic        req1_wr,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        img_mounted,
  output logic        owner,
  output logic        busy,
  output logic        act,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_owner_q;
  logic [31:0] lba_q;
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic        busy_q;
  logic        act_q;
  logic [23:0] timer_q;
  logic [19:0] hold_q;

  logic        v0, v1, inv0, inv1;
  logic        grant_vld;
  logic        grant_idx;
  logic [23:0] timer_d;
  logic        timeout;
  logic [1:0]  owner_bit;

  // Request decode, round-robin pick and timer expiry.
  always_comb begin
    v0        = req0_rd ^ req0_wr;
    v1        = req1_rd ^ req1_wr;
    inv0      = req0_rd & req0_wr;
    inv1      = req1_rd & req1_wr;
    // A late ack from an abandoned transfer must fall before anyone is granted.
    grant_vld = (v0 | v1) & ~sd_ack;
    grant_idx = (v0 & v1) ? ~last_owner_q : v1;
    timer_d   = timer_q + 24'd1;
    timeout   = (timer_d == ACK_TIMEOUT);
    owner_bit = owner_q ? 2'b10 : 2'b01;
  end

  // Main sequencer with registered strobes, pulses, busy and activity LED.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      lba_q        <= 32'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      busy_q       <= 1'b0;
      act_q        <= 1'b0;
      timer_q      <= 24'd0;
      hold_q       <= 20'd0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      // Outside a transfer the hold counter drains; act follows its next value.
      hold_q <= (hold_q != 20'd0) ? hold_q - 20'd1 : 20'd0;
      act_q  <= (hold_q > 20'd1);
      case (state_q)
        S_IDLE: begin
          err_q <= {inv1, inv0};
          if (grant_vld) begin
            owner_q      <= grant_idx;
            last_owner_q <= grant_idx;
            lba_q        <= grant_idx ? req1_lba : req0_lba;
            rd_q         <= grant_idx ? req1_rd : req0_rd;
            wr_q         <= grant_idx ? req1_wr : req0_wr;
            timer_q      <= 24'd0;
            busy_q       <= 1'b1;
            act_q        <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= timer_d;
          act_q   <= 1'b1;
          if (img_mounted || (!sd_ack && timeout)) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= owner_bit;
            busy_q  <= 1'b0;
            hold_q  <= ACT_HOLD;
            act_q   <= (ACT_HOLD != 20'd0);
            state_q <= S_GAP;
          end else if (sd_ack) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          timer_q <= timer_d;
          act_q   <= 1'b1;
          // Abort beats a same-cycle ack fall; an ack fall beats expiry.
          if (img_mounted || (sd_ack && timeout)) begin
            err_q   <= owner_bit;
            busy_q  <= 1'b0;
            hold_q  <= ACT_HOLD;
            act_q   <= (ACT_HOLD != 20'd0);
            state_q <= S_GAP;
          end else if (!sd_ack) begin
            done_q  <= owner_bit;
            busy_q  <= 1'b0;
            hold_q  <= ACT_HOLD;
            act_q   <= (ACT_HOLD != 20'd0);
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign req0_err  = err_q[0];
  assign req1_err  = err_q[1];
  assign sd_lba    = lba_q;
  assign sd_rd     = rd_q;
  assign sd_wr     = wr_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign act       = act_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed steps plus randomized rounds. The bench
// plays both requesters and the HPS side; expected grants come from a
// transaction-level round-robin model and expected outcomes from the ack,
// timeout and abort timing it chooses for each round.
module tb_sd_req_arbiter;

  localparam int TO   = 100;
  localparam int HOLD = 50;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] req0_lba = '0, req1_lba = '0;
  logic        req0_rd = 1'b0, req0_wr = 1'b0, req1_rd = 1'b0, req1_wr = 1'b0;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic        img_mounted = 1'b0;
  logic        owner, busy, act;
  logic [1:0]  dbg_state;
  logic [40:0] all_outs;

  sd_req_arbiter #(.ACK_TIMEOUT(24'(TO)), .ACT_HOLD(20'(HOLD))) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0_lba(req0_lba), .req0_rd(req0_rd), .req0_wr(req0_wr),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_lba(req1_lba), .req1_rd(req1_rd), .req1_wr(req1_wr),
    .req1_done(req1_done), .req1_err(req1_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .img_mounted(img_mounted), .owner(owner), .busy(busy), .act(act),
    .dbg_state(dbg_state)
  );

  assign all_outs = {sd_lba, sd_rd, sd_wr, req0_done, req0_err, req1_done,
                     req1_err, owner, busy, act};

  // Clock generation.
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  // Requester model state and round-robin reference.
  logic        r_rd[2];
  logic        r_wr[2];
  logic [31:0] r_lba[2];
  bit          pend[2];
  int          m_last = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic done_of(input int i);
    return (i == 1) ? req1_done : req0_done;
  endfunction

  function automatic logic err_of(input int i);
    return (i == 1) ? req1_err : req0_err;
  endfunction

  task automatic drive_reqs();
    req0_rd = r_rd[0]; req0_wr = r_wr[0]; req0_lba = r_lba[0];
    req1_rd = r_rd[1]; req1_wr = r_wr[1]; req1_lba = r_lba[1];
  endtask

  task automatic new_req(input int i);
    r_rd[i]  = 1'($urandom_range(0, 1));
    r_wr[i]  = ~r_rd[i];
    r_lba[i] = $urandom;
    pend[i]  = 1'b1;
  endtask

  task automatic drop(input int i);
    r_rd[i] = 1'b0; r_wr[i] = 1'b0; pend[i] = 1'b0;
    drive_reqs();
  endtask

  function automatic int next_grant();
    int w;
    if (pend[0] && pend[1]) w = 1 - m_last;
    else w = pend[1] ? 1 : 0;
    m_last = w;
    return w;
  endfunction

  // One transaction from the grant onwards. kind 0: normal, 1: timeout,
  // 2: abort with ack still high, 3: abort together with the ack fall.
  // Returns at the negedge where the next round's requests are driven.
  task automatic serve(input int w, input int kind, input int rise, input int len,
                       input int hold_ack);
    int cnt;
    bit seen;
    tick();
    chk("grant_owner", owner, w);
    chk("grant_lba", sd_lba, r_lba[w]);
    chk("grant_strobe", {sd_rd, sd_wr}, {r_rd[w], r_wr[w]});
    chk("grant_busy_act", {busy, act}, 2'b11);
    if (kind == 1) begin
      cnt = 0; seen = 0;
      while (cnt < TO + 20 && !err_of(w)) begin
        tick(); cnt++;
        if (done_of(w)) seen = 1;
      end
      chk("to_latency", cnt, TO);
      chk("to_outs", {sd_rd, sd_wr, busy, done_of(w)}, 4'b0000);
      drop(w);
      tick();
      chk("to_err_once", {err_of(w), done_of(w)}, 2'b00);
      chk("to_no_done", seen, 0);
    end else begin
      repeat (rise) tick();
      chk("issue_hold", {sd_rd, sd_wr, busy}, {r_rd[w], r_wr[w], 1'b1});
      sd_ack = 1'b1;
      tick();
      chk("ack_rise_drop", {sd_rd, sd_wr, busy}, 3'b001);
      if (kind == 0) begin
        seen = 0;
        repeat (len - 1) begin
          tick();
          if (done_of(w) || err_of(w)) seen = 1;
        end
        sd_ack = 1'b0;
        tick();
        chk("done_pulse", {done_of(w), err_of(w), busy, act}, 4'b1001);
        chk("early_pulse", seen, 0);
        chk("owner_hold", {owner, sd_lba}, {w[0], r_lba[w]});
        drop(w);
        tick();
        chk("done_once", {done_of(w), err_of(w)}, 2'b00);
      end else begin
        repeat (len) tick();
        img_mounted = 1'b1;
        if (kind == 3) sd_ack = 1'b0;
        tick();
        img_mounted = 1'b0;
        chk("abort_err", {err_of(w), done_of(w), sd_rd, sd_wr, busy}, 5'b10000);
        drop(w);
        if (kind == 2) begin
          repeat (hold_ack) begin
            tick();
            chk("abort_nogrant", {sd_rd, sd_wr, busy, done_of(w)}, 4'b0000);
          end
          sd_ack = 1'b0;
        end else begin
          tick();
          chk("abort_nodone", {done_of(w), err_of(w)}, 2'b00);
        end
      end
    end
  endtask

  task automatic do_round(input bit add_new, input int kind, input int rise,
                          input int len, input int hold_ack);
    int w;
    if (add_new) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
    end
    if (!pend[0] && !pend[1]) return;
    drive_reqs();
    w = next_grant();
    serve(w, kind, rise, len, hold_ack);
  endtask

  task automatic reset_mid(input bit in_xfer);
    r_rd[1] = 1'b0; r_wr[1] = 1'b1; r_lba[1] = 32'hDEAD_BEEF; pend[1] = 1'b1;
    drive_reqs();
    void'(next_grant());
    tick();
    chk("rst_pre", {owner, sd_wr, busy, act}, 4'b1111);
    if (in_xfer) begin
      sd_ack = 1'b1;
      tick();
      chk("rst_pre_xfer", {sd_wr, busy}, 2'b01);
    end
    #2 RESET_N = 1'b0;
    #1 chk("rst_async", all_outs, 41'd0);
    sd_ack = 1'b0;
    drop(1);
    tick(); tick();
    RESET_N = 1'b1;
    m_last = 1;
    tick();
  endtask

  initial begin
    int cnt;
    int kind;
    int k;
    for (int i = 0; i < 2; i++) begin
      r_rd[i] = 1'b0; r_wr[i] = 1'b0; r_lba[i] = '0; pend[i] = 1'b0;
    end
    repeat (3) tick();
    chk("reset_outs", all_outs, 41'd0);
    RESET_N = 1'b1;
    tick();
    chk("post_reset_idle", all_outs, 41'd0);

    // Contention from reset: requester 0 first, then strict alternation.
    r_rd[0] = 1'b1; r_wr[0] = 1'b0; r_lba[0] = 32'h0000_0A00; pend[0] = 1'b1;
    r_rd[1] = 1'b0; r_wr[1] = 1'b1; r_lba[1] = 32'h0000_0B00; pend[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
      do_round(1'b0, 0, 2, 3, 0);
    end
    do_round(1'b0, 0, 1, 2, 0);

    // Single read from requester 0.
    r_rd[0] = 1'b1; r_wr[0] = 1'b0; r_lba[0] = 32'h0000_0123; pend[0] = 1'b1;
    do_round(1'b0, 0, 4, 20, 0);

    // Invalid requests: error pulse, no grant, round-robin pointer untouched.
    for (int i = 0; i < 2; i++) begin
      r_rd[i] = 1'b1; r_wr[i] = 1'b1;
      drive_reqs();
      tick();
      chk("inv_err", {err_of(i), err_of(1 - i), done_of(i)}, 3'b100);
      chk("inv_quiet", {sd_rd, sd_wr, busy}, 3'b000);
      r_rd[i] = 1'b0; r_wr[i] = 1'b0;
      drive_reqs();
      tick();
      chk("inv_err_once", {err_of(i), busy}, 2'b00);
    end
    new_req(0); new_req(1);
    do_round(1'b0, 0, 2, 2, 0);
    do_round(1'b0, 0, 2, 2, 0);

    // Timeout on requester 1, then a fresh grant right after the gap.
    r_rd[1] = 1'b1; r_wr[1] = 1'b0; r_lba[1] = 32'h0000_7777; pend[1] = 1'b1;
    do_round(1'b0, 1, 0, 0, 0);
    new_req(0);
    do_round(1'b0, 0, 2, 3, 0);

    // Ack fall in the very cycle the timer expires: done wins.
    new_req(1);
    do_round(1'b0, 0, 5, 94, 0);

    // Abort mid-transfer with the other requester waiting, then abort
    // coinciding with the ack fall.
    new_req(0); new_req(1);
    do_round(1'b0, 2, 3, 5, 3);
    do_round(1'b0, 3, 2, 4, 0);

    // Randomized rounds.
    for (int j = 0; j < 24; j++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) kind = 0;
      else if (k == 6) kind = 1;
      else if (k <= 8) kind = 2;
      else kind = 3;
      do_round(1'b1, kind, $urandom_range(1, 6), $urandom_range(1, 20),
               $urandom_range(2, 4));
    end
    while (pend[0] || pend[1]) do_round(1'b0, 0, 1, 2, 0);

    // Activity LED hold time.
    cnt = 0;
    while (act && cnt < HOLD + 10) begin tick(); cnt++; end
    chk("act_idle_low", act, 0);
    r_rd[0] = 1'b0; r_wr[0] = 1'b1; r_lba[0] = 32'h0000_0042; pend[0] = 1'b1;
    do_round(1'b0, 0, 3, 6, 0);
    cnt = 0;
    while (act && cnt < HOLD + 10) begin cnt++; tick(); end
    chk("act_hold_len", cnt, HOLD - 1);
    chk("act_low_after", act, 0);

    // Asynchronous reset in the middle of a transfer.
    reset_mid(1'b0);
    reset_mid(1'b1);
    new_req(0); new_req(1);
    do_round(1'b0, 0, 2, 2, 0);
    do_round(1'b0, 0, 2, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single HPS virtual-disk sector channel (sd_lba, sd_rd, sd_wr, sd_ack) between two requesters: requester 0 is the SPI virtual SD card, requester 1 is the drive/cart image loader.
- Grants one requester at a time using round-robin arbitration.
- Sequences the request/ack handshake and reports completion, timeout or abort back to the granted requester.
- Drives the buffer-owner select for the sd_buff mux and the disk-activity LED.

Parameters:
- ACK_TIMEOUT, 24'd16000000: cycles allowed from grant to sd_ack falling before the transfer is aborted.
- ACT_HOLD, 20'd1000000: cycles the act output stays high after the last transfer ends.

Ports:
- CLK  in  1  system clock (clk_sys)
- RESET_N  in  1  asynchronous active-low reset
- req0_lba  in  32  sector address, requester 0
- req0_rd  in  1  read request level, requester 0
- req0_wr  in  1  write request level, requester 0
- req0_done  out  1  one-cycle success pulse, requester 0
- req0_err  out  1  one-cycle error pulse, requester 0
- req1_lba, req1_rd, req1_wr, req1_done, req1_err  same widths and meanings, requester 1
- sd_lba  out  32  LBA to hps_io
- sd_rd  out  1  read strobe level to hps_io
- sd_wr  out  1  write strobe level to hps_io
- sd_ack  in  1  HPS ack: high for the whole buffer transfer
- img_mounted  in  1  image change pulse; aborts any active transfer
- owner  out  1  granted requester index; selects the sd_buff mux
- busy  out  1  high in ISSUE and XFER
- act  out  1  activity LED

Behaviour:
- Reset values: all outputs 0, state IDLE, last_owner = 1 (so requester 0 wins first), timers 0.
- States: IDLE, ISSUE, XFER, GAP.
- Request validity: req valid = rd XOR wr. A requester with rd and wr both high gets an err pulse in IDLE, with no grant and no change to last_owner.
- Arbitration in IDLE:
  - One valid request: grant it.
  - Both valid: grant the index != last_owner.
  - On grant, in the same edge: latch owner, set last_owner, latch sd_lba from reqN_lba, set sd_rd or sd_wr from reqN_rd/wr, clear the timer, go to ISSUE.
  - Request-to-strobe latency is 1 cycle.
- ISSUE: sd_rd/sd_wr held. On sd_ack high, drop sd_rd/sd_wr and go to XFER.
- XFER: on sd_ack low, pulse reqN_done for 1 cycle and go to GAP.
- GAP: exactly one cycle, no grant. Requesters must drop rd/wr in the cycle after done/err; a level still high in IDLE is a new request.
- sd_lba and owner hold their values from grant until the next grant. They do not change in GAP or IDLE.
- Timeout: the timer increments every cycle in ISSUE and XFER. When it reaches ACK_TIMEOUT:
  - drop sd_rd/sd_wr, pulse reqN_err, go to GAP;
  - a late sd_ack is ignored until it falls, and IDLE does not grant while sd_ack is high.
- Abort: img_mounted in ISSUE or XFER has the same effect as a timeout (err pulse, strobes dropped, GAP). img_mounted in IDLE or GAP has no effect.
- Simultaneous events:
  - sd_ack falling and timeout expiry in the same cycle: done wins.
  - img_mounted and sd_ack falling in the same cycle: err wins.
- act:
  - high while busy;
  - a hold counter reloads to ACT_HOLD when ISSUE/XFER is left, counts down to 0, and act stays high while it is nonzero;
  - a new grant holds act high continuously.
- Reset asserted mid-transfer: immediately returns to reset values, with sd_rd/sd_wr low the same instant (asynchronous).

Test Plan:
- Single read: req0_rd=1, lba=0x00000123; sd_ack rises 5 cycles later and falls 20 cycles after that.
  -> sd_rd high 1 cycle after the request; sd_lba=0x123; sd_rd drops on the ack rise; req0_done pulses exactly once, 1 cycle after the ack fall; owner=0 throughout.
- Contention: req0_rd and req1_wr asserted together from reset.
  -> Requester 0 is served first and requester 1 second (owner=1, sd_wr=1, sd_lba=req1_lba). Requester 0 then re-requests while requester 1 keeps requesting: grants strictly alternate 0,1,0,1.
- Timeout: ACK_TIMEOUT=100, req1_rd with sd_ack never asserted.
  -> req1_err pulses at cycle 100 after the grant; sd_rd low; no req1_done; the next request is granted after GAP.
- Abort: img_mounted pulsed mid-XFER with sd_ack still high.
  -> reqN_err pulses once; no grant occurs until sd_ack falls; no done pulse.
- Invalid request: req0_rd=req0_wr=1.
  -> req0_err pulse; sd_rd and sd_wr stay 0; busy stays 0.
- Activity: ACT_HOLD=50, one transfer.
  -> act high from grant through 50 cycles after leaving XFER, then 0. Asserting RESET_N=0 mid-XFER forces all outputs to 0 asynchronously.
